lcd_id_detect: RTL

//  Identifies the attached RGB LCD panel at power-up by reading the panel strap pins on the shared
//  RGB data bus (M0=lcd_rgb[7], M1=lcd_rgb[15], M2=lcd_rgb[23]) while the bus is released.

---
 rtl/lcd_id_detect_pkg.sv | 41 ++++
 rtl/lcd_id_detect_strap_sync.sv | 24 ++
 rtl/lcd_id_detect.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lcd_id_detect_pkg.sv
// rtl/lcd_id_detect_pkg.sv - shared panel ID constants, strap positions and FSM states
// Purpose: definitions shared by lcd_id_detect and the pixel-clock divider.
// Contents: LCD_ID_* constants, STRAP_M* bus bit positions, state_t, decode helpers.
package lcd_id_detect_pkg;

  localparam logic [15:0] LCD_ID_4342 = 16'h4342;
  localparam logic [15:0] LCD_ID_7084 = 16'h7084;
  localparam logic [15:0] LCD_ID_7016 = 16'h7016;
  localparam logic [15:0] LCD_ID_4384 = 16'h4384;
  localparam logic [15:0] LCD_ID_1018 = 16'h1018;

  localparam int STRAP_M0 = 7;
  localparam int STRAP_M1 = 15;
  localparam int STRAP_M2 = 23;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // code is {M2,M1,M0}
  function automatic logic [15:0] decode_id(input logic [2:0] code);
    case (code)
      3'b000:  return LCD_ID_4342;
      3'b001:  return LCD_ID_7084;
      3'b010:  return LCD_ID_7016;
      3'b100:  return LCD_ID_4384;
      3'b101:  return LCD_ID_1018;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic code_supported(input logic [2:0] code);
    case (code)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lcd_id_detect_strap_sync.sv
// rtl/lcd_id_detect_strap_sync.sv - 2-FF synchronizer for the panel strap inputs
// Ports: clk, rst (async active-high, clears to 0), d (async input), q (synchronized output).
module strap_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lcd_id_detect.sv
// rtl/lcd_id_detect.sv - power-up RGB LCD panel identification from bus strap pins
// Ports: clk, rst (async active-high), rescan (pulse, honoured when !busy),
//        lcd_rgb_in[23:0] (pad input; straps M0/M1/M2 on bits 7/15/23),
//        lcd_rgb_oe (1 = video drives bus), lcd_id[15:0], id_valid, id_err, busy.
module lcd_id_detect
  import lcd_id_detect_pkg::*;
#(
  parameter int SETTLE_CYCLES = 5000,
  parameter int SAMPLE_NUM    = 8,
  parameter int SAMPLE_GAP    = 64,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rescan,
  input  logic [23:0] lcd_rgb_in,
  output logic        lcd_rgb_oe,
  output logic [15:0] lcd_id,
  output logic        id_valid,
  output logic        id_err,
  output logic        busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int GW = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int NW = (SAMPLE_NUM > 1) ? $clog2(SAMPLE_NUM) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(SAMPLE_GAP - 1);
  localparam logic [NW-1:0] NUM_LAST    = NW'(SAMPLE_NUM - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  logic [2:0] straps;

  // Remaining bus bits carry video data and are not part of identification.
  logic unused_rgb;
  assign unused_rgb = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

  strap_sync #(.WIDTH(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({lcd_rgb_in[STRAP_M2], lcd_rgb_in[STRAP_M1], lcd_rgb_in[STRAP_M0]}),
    .q   (straps)
  );

  state_t      state, state_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [NW-1:0] smp_cnt, smp_n;
  logic [RW-1:0] retry, retry_n;
  logic [2:0]    ref_code, ref_n;
  logic          unstable, unstable_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      smp_cnt    <= '0;
      retry      <= '0;
      ref_code   <= '0;
      unstable   <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      gap_cnt    <= gap_n;
      smp_cnt    <= smp_n;
      retry      <= retry_n;
      ref_code   <= ref_n;
      unstable   <= unstable_n;
    end
  end

  always_comb begin
    state_n    = state;
    settle_n   = settle_cnt;
    gap_n      = gap_cnt;
    smp_n      = smp_cnt;
    retry_n    = retry;
    ref_n      = ref_code;
    unstable_n = unstable;
    case (state)
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_n = '0;
          gap_n    = '0;
          smp_n    = '0;
          state_n  = ST_SAMPLE;
        end else begin
          settle_n = settle_cnt + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (gap_cnt == GAP_LAST) begin
          gap_n = '0;
          if (smp_cnt == '0) begin
            ref_n = straps;
          end
          if (smp_cnt != '0 && straps != ref_code) begin
            if (retry < RETRY_MAX) begin
              retry_n  = retry + 1'b1;
              settle_n = '0;
              state_n  = ST_SETTLE;
            end else begin
              unstable_n = 1'b1;
              state_n    = ST_DONE;
            end
          end else if (smp_cnt == NUM_LAST) begin
            state_n = ST_DONE;
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        // busy is still 1 on the edge DONE is entered, so a rescan there is dropped.
        if (rescan && !busy) begin
          unstable_n = 1'b0;
          retry_n    = '0;
          settle_n   = '0;
          state_n    = ST_SETTLE;
        end
      end
      default: state_n = ST_SETTLE;
    endcase
  end

  // Outputs follow the state one edge later so that id, valid and oe always move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_rgb_oe <= 1'b0;
      lcd_id     <= 16'h0000;
      id_valid   <= 1'b0;
      id_err     <= 1'b0;
      busy       <= 1'b1;
    end else if (state == ST_DONE) begin
      lcd_rgb_oe <= 1'b1;
      busy       <= 1'b0;
      if (unstable) begin
        lcd_id   <= 16'h0000;
        id_valid <= 1'b0;
        id_err   <= 1'b1;
      end else begin
        lcd_id   <= decode_id(ref_code);
        id_valid <= code_supported(ref_code);
        id_err   <= !code_supported(ref_code);
      end
    end else begin
      lcd_rgb_oe <= 1'b0;
      busy       <= 1'b1;
      id_valid   <= 1'b0;
      id_err     <= 1'b0;
    end
  end

endmodule
